// File: rtl/cpu7_pkg.sv
// Shared CPU7 types and defaults.
// Scheduler state encoding and counter width.
package cpu7_pkg;

  localparam int DLY_W_DEF = 64;

  typedef logic sched_state_t;

  localparam sched_state_t S_RUN  = 1'b0;
  localparam sched_state_t S_SCAN = 1'b1;

endpackage

// File: rtl/core_wake_timer.sv
// Per-core halted/sleeping status and wake timestamp.
// Drives runnable from the wrap-safe delay comparison.
module core_wake_timer import cpu7_pkg::*; #(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DLY_W-1:0] dlyc,
  input  logic             set_sleep,
  input  logic [DLY_W-1:0] ticks,
  input  logic             set_halt,
  input  logic             wake,
  output logic             runnable
);

  localparam logic [DLY_W-1:0] MAX_T =
    {1'b0, {(DLY_W-1){1'b1}}};

  logic             halted;
  logic             sleeping;
  logic [DLY_W-1:0] wake_at;
  logic [DLY_W-1:0] clamped;
  logic [DLY_W-1:0] diff;

  assign clamped  = ticks[DLY_W-1] ? MAX_T : ticks;
  assign diff     = dlyc - wake_at;
  assign runnable = !halted && (!sleeping || !diff[DLY_W-1]);

  // Status latch; an external wake beats a same-cycle sleep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted   <= 1'b0;
      sleeping <= 1'b0;
      wake_at  <= '0;
    end else begin
      if (set_halt)
        halted <= 1'b1;
      if (wake)
        sleeping <= 1'b0;
      else if (set_sleep)
        sleeping <= 1'b1;
      if (set_sleep)
        wake_at <= dlyc + clamped;
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Round-robin CPU7 core scheduler.
// Scans one candidate per cycle, grants the first runnable.
module core_scheduler import cpu7_pkg::*; #(
  parameter int CORES = 4,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     next_req,
  input  logic                     sleep_en,
  input  logic [DLY_W-1:0]         sleep_ticks,
  input  logic                     halt_en,
  input  logic [CORES-1:0]         wake_en,
  output logic [$clog2(CORES)-1:0] pxr,
  output logic [CORES-1:0]         acore_en,
  output logic                     grant_valid,
  output logic                     all_idle,
  output logic [DLY_W-1:0]         dlyc
);

  localparam int IW = $clog2(CORES);
  localparam logic [IW-1:0] LAST = IW'(CORES - 1);

  sched_state_t   state;
  logic [IW-1:0]  cand;
  logic [IW-1:0]  scan_cnt;
  logic [IW-1:0]  cand_nxt;
  logic [IW-1:0]  pxr_nxt;
  logic [CORES-1:0] runnable;
  logic [CORES-1:0] cur_sel;
  logic           in_run;

  assign in_run   = (state == S_RUN);
  assign cand_nxt = (cand == LAST) ? '0 : cand + 1'b1;
  assign pxr_nxt  = (pxr == LAST) ? '0 : pxr + 1'b1;

  for (genvar i = 0; i < CORES; i++) begin : g_core
    assign cur_sel[i] = (pxr == IW'(i));

    core_wake_timer #(.DLY_W(DLY_W)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .dlyc      (dlyc),
      .set_sleep (in_run && sleep_en && cur_sel[i]),
      .ticks     (sleep_ticks),
      .set_halt  (in_run && halt_en && cur_sel[i]),
      .wake      (wake_en[i]),
      .runnable  (runnable[i])
    );
  end

  // Scheduler FSM, delay counter and grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_SCAN;
      cand        <= '0;
      scan_cnt    <= '0;
      pxr         <= '0;
      acore_en    <= '0;
      grant_valid <= 1'b0;
      all_idle    <= 1'b0;
      dlyc        <= '0;
    end else begin
      dlyc        <= dlyc + 1'b1;
      grant_valid <= 1'b0;
      unique case (state)
        S_RUN: begin
          if (next_req) begin
            cand     <= pxr_nxt;
            scan_cnt <= '0;
            acore_en <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (runnable[cand]) begin
            pxr         <= cand;
            acore_en    <= CORES'(1) << cand;
            grant_valid <= 1'b1;
            all_idle    <= 1'b0;
            state       <= S_RUN;
          end else begin
            cand <= cand_nxt;
            if (scan_cnt == LAST) begin
              all_idle <= 1'b1;
              scan_cnt <= '0;
            end else begin
              scan_cnt <= scan_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler (CORES=4, DLY_W=8).
// Random requests checked against a behavioural scheduler model.
module tb_core_scheduler;

  localparam int CORES = 4;
  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int HALF  = 128;
  localparam int MAXT  = 127;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            next_req = 1'b0;
  logic            sleep_en = 1'b0;
  logic [DW-1:0]   sleep_ticks = '0;
  logic            halt_en = 1'b0;
  logic [CORES-1:0] wake_en = '0;
  logic [IW-1:0]   pxr;
  logic [CORES-1:0] acore_en;
  logic            grant_valid;
  logic            all_idle;
  logic [DW-1:0]   dlyc;

  core_scheduler #(.CORES(CORES), .DLY_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_req    (next_req),
    .sleep_en    (sleep_en),
    .sleep_ticks (sleep_ticks),
    .halt_en     (halt_en),
    .wake_en     (wake_en),
    .pxr         (pxr),
    .acore_en    (acore_en),
    .grant_valid (grant_valid),
    .all_idle    (all_idle),
    .dlyc        (dlyc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit m_halt  [CORES];
  bit m_sleep [CORES];
  int m_wake  [CORES];
  int m_pxr;
  int mdly;
  bit m_idle;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_run(input int c);
    int age;
    age = (mdly - m_wake[c]) & 255;
    return !m_halt[c] && (!m_sleep[c] || age < HALF);
  endfunction

  function automatic logic [CORES-1:0] onehot(input int c);
    logic [CORES-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    mdly = (mdly + 1) % 256;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_req = 1'b0; sleep_en = 1'b0;
    halt_en = 1'b0; wake_en = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < CORES; i++) begin
      m_halt[i] = 0; m_sleep[i] = 0; m_wake[i] = 0;
    end
    m_pxr = 0; mdly = 0; m_idle = 0;
    chk("rst_pxr", pxr, 0);
    chk("rst_acore", acore_en, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_idle", all_idle, 0);
    chk("rst_dlyc", dlyc, 0);
    rst_n = 1'b1;
  endtask

  task automatic scan(input int start, input int maxc);
    int c;
    int miss;
    bit got;
    bit exp_g;
    c = start; miss = 0; got = 0;
    for (int k = 0; k < maxc && !got; k++) begin
      exp_g = m_run(c);
      tick();
      chk("grant_valid", grant_valid, exp_g);
      chk("dlyc", dlyc, mdly);
      if (exp_g) begin
        m_pxr = c; m_idle = 0; got = 1;
        chk("pxr", pxr, c);
        chk("acore_en", acore_en, onehot(c));
      end else begin
        miss++;
        if (miss == CORES) begin
          m_idle = 1; miss = 0;
        end
        chk("acore_scan", acore_en, 0);
      end
      chk("all_idle", all_idle, m_idle);
      c = (c + 1) % CORES;
    end
    if (got) begin
      tick();
      chk("gv_pulse", grant_valid, 0);
      chk("pxr_hold", pxr, m_pxr);
    end
  endtask

  task automatic idle(input int n, input bit rnd_wake);
    logic [CORES-1:0] wk;
    for (int k = 0; k < n; k++) begin
      wk = '0;
      if (rnd_wake && $urandom_range(0, 7) == 0)
        wk = CORES'($urandom_range(0, 15));
      wake_en = wk;
      for (int i = 0; i < CORES; i++)
        if (wk[i]) m_sleep[i] = 0;
      tick();
      wake_en = '0;
      chk("run_gv", grant_valid, 0);
      chk("run_pxr", pxr, m_pxr);
      chk("run_acore", acore_en, onehot(m_pxr));
      chk("run_dlyc", dlyc, mdly);
    end
  endtask

  task automatic request(input bit slp, input int ticks,
                         input bit hlt, input logic [CORES-1:0] wk,
                         input int maxc);
    logic [31:0] tv;
    tv = ticks;
    next_req = 1'b1; sleep_en = slp;
    sleep_ticks = tv[DW-1:0];
    halt_en = hlt; wake_en = wk;
    if (hlt) m_halt[m_pxr] = 1;
    if (slp) begin
      m_sleep[m_pxr] = 1;
      m_wake[m_pxr] = (mdly + (ticks > MAXT ? MAXT : ticks)) % 256;
    end
    for (int i = 0; i < CORES; i++)
      if (wk[i]) m_sleep[i] = 0;
    tick();
    next_req = 1'b0; sleep_en = 1'b0;
    halt_en = 1'b0; wake_en = '0;
    chk("req_acore", acore_en, 0);
    chk("req_gv", grant_valid, 0);
    scan((m_pxr + 1) % CORES, maxc);
  endtask

  initial begin
    do_reset();
    scan(0, 10);

    for (int i = 0; i < 4; i++)
      request(0, 0, 0, '0, 600);

    request(0, 0, 0, '0, 600);
    request(1, 20, 0, '0, 600);
    request(0, 0, 0, '0, 600);
    request(0, 0, 0, '0, 600);
    request(0, 0, 0, '0, 600);
    idle(30, 0);
    for (int i = 0; i < 4; i++)
      request(0, 0, 0, '0, 600);

    while (m_pxr != 1)
      request(0, 0, 0, '0, 600);
    request(0, 0, 0, '0, 600);
    request(1, 255, 0, 4'b0100, 600);
    for (int i = 0; i < 4; i++)
      request(0, 0, 0, '0, 600);

    while (mdly != 250)
      idle(1, 0);
    request(1, 10, 0, '0, 600);
    for (int i = 0; i < 6; i++)
      request(0, 0, 0, '0, 600);
    request(1, 200, 0, '0, 600);
    for (int i = 0; i < 6; i++)
      request(0, 0, 0, '0, 600);

    for (int n = 0; n < 120; n++) begin
      idle($urandom_range(0, 4), 1);
      request($urandom_range(0, 2) == 0,
              $urandom_range(0, 255), 0,
              ($urandom_range(0, 3) == 0) ?
                CORES'($urandom_range(0, 15)) : '0,
              600);
    end

    request(0, 0, 0, 4'b1111, 600);
    for (int i = 0; i < CORES; i++)
      request(0, 0, 1, '0, 40);
    chk("halt_idle", all_idle, 1);
    chk("halt_acore", acore_en, 0);

    do_reset();
    scan(0, 10);
    request(0, 0, 0, '0, 600);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
